// File: rtl/pulse_cmd_pkg.sv
// Purpose: shared types and constants for the pulse generator serial command path.
// Contents: top-level and transmit-sequencer state enums, control byte layout,
//           NAK pattern, response queue sizing and named parameter-register addresses.
package pulse_cmd_pkg;

    // Frame decoder states
    typedef enum logic [1:0] {
        RECV = 2'd0,
        EXEC = 2'd1,
        SEND = 2'd2
    } state_t;

    // Transmit sequencer states
    typedef enum logic [1:0] {
        TX_IDLE      = 2'd0,
        TX_WAIT_FREE = 2'd1,
        TX_HOLD      = 2'd2
    } tx_state_t;

    // Control byte layout: bit7 selects read, low bits carry the address
    localparam int unsigned CTRL_READ_BIT = 7;
    localparam int unsigned ADDR_W        = 7;

    // Response to a bad-address frame is the checksum inverted
    localparam logic [7:0] NAK_XOR = 8'hFF;

    // Response queue: up to 8 bytes
    localparam int unsigned TXQ_BYTES = 8;
    localparam int unsigned TXQ_W     = 8 * TXQ_BYTES;
    localparam int unsigned TXQ_CNT_W = 4;

    // Named pulse-parameter register addresses
    localparam logic [ADDR_W-1:0] DELAY  = 7'd0;
    localparam logic [ADDR_W-1:0] PERIOD = 7'd1;
    localparam logic [ADDR_W-1:0] PULSE1 = 7'd2;
    localparam logic [ADDR_W-1:0] PULSE2 = 7'd3;
    localparam logic [ADDR_W-1:0] BLOCK  = 7'd4;
    localparam logic [ADDR_W-1:0] CPMG   = 7'd5;
    localparam logic [ADDR_W-1:0] ATT    = 7'd6;
    localparam logic [ADDR_W-1:0] NUTW   = 7'd7;
    localparam logic [ADDR_W-1:0] NUTD   = 7'd8;

endpackage

// File: rtl/pulse_cmd_tx_seq.sv
// Purpose: response byte queue feeding the UART transmitter.
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   i_load        - load i_count bytes from i_bytes (LSB byte goes out first)
//   i_count       - number of bytes to send (0..8)
//   i_bytes       - packed response bytes
//   i_tx_busy     - UART transmitter busy
//   o_tx_start    - one-cycle pulse: load o_tx_byte into the UART
//   o_tx_byte     - byte to transmit
//   o_idle_c      - queue empty and no handshake in progress
module pulse_cmd_tx_seq
    import pulse_cmd_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_load,
    input  logic [TXQ_CNT_W-1:0] i_count,
    input  logic [TXQ_W-1:0]     i_bytes,
    input  logic                 i_tx_busy,
    output logic                 o_tx_start,
    output logic [7:0]           o_tx_byte,
    output logic                 o_idle_c
);

    tx_state_t            r_state,    w_state_nxt;
    logic [TXQ_W-1:0]     r_buf,      w_buf_nxt;
    logic [TXQ_CNT_W-1:0] r_left,     w_left_nxt;
    logic                 r_hold,     w_hold_nxt;
    logic                 r_tx_start, w_tx_start_nxt;
    logic [7:0]           r_tx_byte,  w_tx_byte_nxt;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= TX_IDLE;
            r_buf      <= '0;
            r_left     <= '0;
            r_hold     <= 1'b0;
            r_tx_start <= 1'b0;
            r_tx_byte  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_buf      <= w_buf_nxt;
            r_left     <= w_left_nxt;
            r_hold     <= w_hold_nxt;
            r_tx_start <= w_tx_start_nxt;
            r_tx_byte  <= w_tx_byte_nxt;
        end
    end

    // Next-state: issue a byte when the UART is free, then hold off until busy
    // rises (or two cycles pass) so the same free window cannot issue twice.
    always_comb begin
        w_state_nxt    = r_state;
        w_buf_nxt      = r_buf;
        w_left_nxt     = r_left;
        w_hold_nxt     = r_hold;
        w_tx_start_nxt = 1'b0;
        w_tx_byte_nxt  = r_tx_byte;

        unique case (r_state)
            TX_IDLE: begin
                if (i_load && (i_count != '0)) begin
                    w_buf_nxt   = i_bytes;
                    w_left_nxt  = i_count;
                    w_state_nxt = TX_WAIT_FREE;
                end
            end
            TX_WAIT_FREE: begin
                if (!i_tx_busy) begin
                    w_tx_start_nxt = 1'b1;
                    w_tx_byte_nxt  = r_buf[7:0];
                    w_buf_nxt      = r_buf >> 8;
                    w_left_nxt     = r_left - TXQ_CNT_W'(1);
                    w_hold_nxt     = 1'b0;
                    w_state_nxt    = TX_HOLD;
                end
            end
            TX_HOLD: begin
                if (i_tx_busy || r_hold) begin
                    w_state_nxt = (r_left == '0) ? TX_IDLE : TX_WAIT_FREE;
                end else begin
                    w_hold_nxt = 1'b1;
                end
            end
            default: w_state_nxt = TX_IDLE;
        endcase
    end

    assign o_tx_start = r_tx_start;
    assign o_tx_byte  = r_tx_byte;
    assign o_idle_c   = (r_state == TX_IDLE);

endmodule

// File: rtl/pulse_cmd_regfile.sv
// Purpose: serial command decoder and pulse-parameter register bank.
//   Frames are PAYLOAD_BYTES data bytes (LSB first) then one control byte
//   (bit7 = read, bits[6:0] = address). Writes update a register and answer
//   with the payload checksum; reads answer with the register value; bad
//   addresses answer with the inverted checksum.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   rx_valid, rx_byte   - received byte stream from the UART
//   tx_busy             - UART transmitter busy
//   tx_start, tx_byte   - one-cycle load pulse and byte for the UART
//   regs                - all registers, register i at [i*REG_W +: REG_W]
//   upd                 - one-cycle strobe on the written register's bit
//   frame_done          - one-cycle pulse when a frame executes
//   frame_err           - one-cycle pulse on timeout or bad address
module pulse_cmd_regfile
    import pulse_cmd_pkg::*;
#(
    parameter int unsigned                PAYLOAD_BYTES = 4,
    parameter int unsigned                NUM_REGS      = 9,
    parameter int unsigned                REG_W         = 32,
    parameter logic [NUM_REGS*REG_W-1:0]  RESET_VALS    = '0,
    parameter int unsigned                TIMEOUT_CYC   = 2000000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rx_valid,
    input  logic [7:0]                rx_byte,
    input  logic                      tx_busy,
    output logic                      tx_start,
    output logic [7:0]                tx_byte,
    output logic [NUM_REGS*REG_W-1:0] regs,
    output logic [NUM_REGS-1:0]       upd,
    output logic                      frame_done,
    output logic                      frame_err
);

    localparam int unsigned PAY_W = 8 * PAYLOAD_BYTES;
    localparam int unsigned CNT_W = $clog2(PAYLOAD_BYTES + 1);
    localparam int unsigned TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);

    state_t               r_state,   w_state_nxt;
    logic [CNT_W-1:0]     r_cnt,     w_cnt_nxt;
    logic [7:0]           r_csum,    w_csum_nxt;
    logic [PAY_W-1:0]     r_payload, w_payload_nxt;
    logic [7:0]           r_ctrl,    w_ctrl_nxt;
    logic [TMR_W-1:0]     r_timer,   w_timer_nxt;
    logic [REG_W-1:0]     r_regs     [NUM_REGS];
    logic [REG_W-1:0]     w_regs_nxt [NUM_REGS];
    logic [NUM_REGS-1:0]  r_upd,     w_upd_nxt;
    logic                 r_done,    w_done_nxt;
    logic                 r_err,     w_err_nxt;

    logic                 w_load_c;
    logic [TXQ_CNT_W-1:0] w_resp_cnt;
    logic [TXQ_W-1:0]     w_resp_bytes;
    logic                 w_seq_idle;
    logic                 w_rx_addr_ok;
    logic                 w_ex_addr_ok;
    logic [REG_W-1:0]     w_rd_val;

    assign w_rx_addr_ok = (32'(rx_byte[ADDR_W-1:0]) < NUM_REGS);
    assign w_ex_addr_ok = (32'(r_ctrl[ADDR_W-1:0]) < NUM_REGS);

    // Readback mux for the latched address
    always_comb begin
        w_rd_val = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (r_ctrl[ADDR_W-1:0] == ADDR_W'(i)) w_rd_val = r_regs[i];
        end
    end

    // State and register bank
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= RECV;
            r_cnt     <= '0;
            r_csum    <= '0;
            r_payload <= '0;
            r_ctrl    <= '0;
            r_timer   <= '0;
            r_upd     <= '0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= RESET_VALS[i*REG_W +: REG_W];
            end
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_csum    <= w_csum_nxt;
            r_payload <= w_payload_nxt;
            r_ctrl    <= w_ctrl_nxt;
            r_timer   <= w_timer_nxt;
            r_upd     <= w_upd_nxt;
            r_done    <= w_done_nxt;
            r_err     <= w_err_nxt;
            r_regs    <= w_regs_nxt;
        end
    end

    // Next-state and outputs. Strobes are decoded from the control byte as it
    // arrives so they are visible during the EXEC cycle; the write itself lands
    // at the end of EXEC.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_csum_nxt    = r_csum;
        w_payload_nxt = r_payload;
        w_ctrl_nxt    = r_ctrl;
        w_timer_nxt   = r_timer;
        w_regs_nxt    = r_regs;
        w_upd_nxt     = '0;
        w_done_nxt    = 1'b0;
        w_err_nxt     = 1'b0;
        w_load_c      = 1'b0;
        w_resp_cnt    = '0;
        w_resp_bytes  = '0;

        unique case (r_state)
            RECV: begin
                if (rx_valid) begin
                    // A byte always wins over a same-cycle timeout
                    w_timer_nxt = '0;
                    if (r_cnt == CNT_W'(PAYLOAD_BYTES)) begin
                        w_ctrl_nxt  = rx_byte;
                        w_state_nxt = EXEC;
                        w_done_nxt  = 1'b1;
                        if (!w_rx_addr_ok) begin
                            w_err_nxt = 1'b1;
                        end else if (!rx_byte[CTRL_READ_BIT]) begin
                            w_upd_nxt = NUM_REGS'(1) << rx_byte[ADDR_W-1:0];
                        end
                    end else begin
                        for (int unsigned k = 0; k < PAYLOAD_BYTES; k++) begin
                            if (r_cnt == CNT_W'(k)) w_payload_nxt[8*k +: 8] = rx_byte;
                        end
                        w_csum_nxt = r_csum + rx_byte;
                        w_cnt_nxt  = r_cnt + CNT_W'(1);
                    end
                end else if ((TIMEOUT_CYC != 0) && (r_cnt != '0)) begin
                    if (r_timer == TMR_LAST) begin
                        w_cnt_nxt   = '0;
                        w_csum_nxt  = '0;
                        w_timer_nxt = '0;
                        w_err_nxt   = 1'b1;
                    end else begin
                        w_timer_nxt = r_timer + TMR_W'(1);
                    end
                end
            end
            EXEC: begin
                w_load_c = 1'b1;
                if (!w_ex_addr_ok) begin
                    w_resp_cnt   = TXQ_CNT_W'(1);
                    w_resp_bytes = TXQ_W'(r_csum ^ NAK_XOR);
                end else if (r_ctrl[CTRL_READ_BIT]) begin
                    w_resp_cnt   = TXQ_CNT_W'(PAYLOAD_BYTES);
                    w_resp_bytes = TXQ_W'(w_rd_val);
                end else begin
                    for (int unsigned i = 0; i < NUM_REGS; i++) begin
                        if (r_ctrl[ADDR_W-1:0] == ADDR_W'(i)) w_regs_nxt[i] = r_payload[REG_W-1:0];
                    end
                    w_resp_cnt   = TXQ_CNT_W'(1);
                    w_resp_bytes = TXQ_W'(r_csum);
                end
                w_cnt_nxt   = '0;
                w_csum_nxt  = '0;
                w_timer_nxt = '0;
                w_state_nxt = SEND;
            end
            SEND: begin
                if (w_seq_idle) w_state_nxt = RECV;
            end
            default: w_state_nxt = RECV;
        endcase
    end

    pulse_cmd_tx_seq u_tx_seq (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load_c),
        .i_count    (w_resp_cnt),
        .i_bytes    (w_resp_bytes),
        .i_tx_busy  (tx_busy),
        .o_tx_start (tx_start),
        .o_tx_byte  (tx_byte),
        .o_idle_c   (w_seq_idle)
    );

    // Flatten the bank onto the output bus
    always_comb begin
        regs = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            regs[i*REG_W +: REG_W] = r_regs[i];
        end
    end

    assign upd        = r_upd;
    assign frame_done = r_done;
    assign frame_err  = r_err;

endmodule

// File: tb/tb_pulse_cmd_regfile.sv
// Bench for pulse_cmd_regfile: two instances (REG_W=32 and REG_W=16) share one
// received-byte stream; each has its own UART busy model and expectation queues.
module tb_pulse_cmd_regfile;

    localparam int unsigned PB = 4;
    localparam int unsigned NR = 9;
    localparam int unsigned TO = 100;

    typedef struct packed {
        logic [NR-1:0] upd;
        logic          err;
    } evt_t;

    function automatic logic [31:0] rv_word(input int d, input int i);
        if (d == 0) return 32'h1000_0000 + 32'(i) * 32'h0001_0101;
        return 32'h0000_A000 + 32'(i) * 32'h0000_0011;
    endfunction

    function automatic logic [NR*32-1:0] mk_rv32();
        logic [NR*32-1:0] v;
        v = '0;
        for (int i = 0; i < NR; i++) v[i*32 +: 32] = 32'h1000_0000 + 32'(i) * 32'h0001_0101;
        return v;
    endfunction

    function automatic logic [NR*16-1:0] mk_rv16();
        logic [NR*16-1:0] v;
        v = '0;
        for (int i = 0; i < NR; i++) v[i*16 +: 16] = 16'hA000 + 16'(i) * 16'h0011;
        return v;
    endfunction

    localparam logic [NR*32-1:0] RV32 = mk_rv32();
    localparam logic [NR*16-1:0] RV16 = mk_rv16();

    logic              clk = 1'b0;
    logic              rst;
    logic              rx_valid;
    logic [7:0]        rx_byte;
    logic              busy_a, busy_b, start_a, start_b;
    logic [7:0]        txb_a, txb_b;
    logic [NR*32-1:0]  regs_a;
    logic [NR*16-1:0]  regs_b;
    logic [NR-1:0]     upd_a, upd_b;
    logic              done_a, done_b, err_a, err_b;

    always #5 clk = ~clk;

    pulse_cmd_regfile #(
        .PAYLOAD_BYTES (PB), .NUM_REGS (NR), .REG_W (32),
        .RESET_VALS (RV32), .TIMEOUT_CYC (TO)
    ) u_dut32 (
        .clk (clk), .rst (rst), .rx_valid (rx_valid), .rx_byte (rx_byte),
        .tx_busy (busy_a), .tx_start (start_a), .tx_byte (txb_a),
        .regs (regs_a), .upd (upd_a), .frame_done (done_a), .frame_err (err_a)
    );

    pulse_cmd_regfile #(
        .PAYLOAD_BYTES (PB), .NUM_REGS (NR), .REG_W (16),
        .RESET_VALS (RV16), .TIMEOUT_CYC (TO)
    ) u_dut16 (
        .clk (clk), .rst (rst), .rx_valid (rx_valid), .rx_byte (rx_byte),
        .tx_busy (busy_b), .tx_start (start_b), .tx_byte (txb_b),
        .regs (regs_b), .upd (upd_b), .frame_done (done_b), .frame_err (err_b)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int busy_max = 6;

    // Reference model: register contents per instance and expected outputs
    logic [31:0] mreg [2][NR];
    logic [7:0]  qtx0 [$];
    logic [7:0]  qtx1 [$];
    evt_t        qev0 [$];
    evt_t        qev1 [$];
    int          to0 = 0;
    int          to1 = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    function automatic int bdur();
        if ($urandom_range(0, 3) == 0) return 0;
        return int'($urandom_range(1, busy_max));
    endfunction

    // UART busy models: busy rises just after a tx_start is seen
    initial begin
        int n;
        busy_a = 1'b0;
        forever begin
            @(negedge clk);
            if (start_a === 1'b1) begin
                n = bdur();
                if (n > 0) begin
                    #1 busy_a = 1'b1;
                    repeat (n) @(negedge clk);
                    #1 busy_a = 1'b0;
                end
            end
        end
    end

    initial begin
        int n;
        busy_b = 1'b0;
        forever begin
            @(negedge clk);
            if (start_b === 1'b1) begin
                n = bdur();
                if (n > 0) begin
                    #1 busy_b = 1'b1;
                    repeat (n) @(negedge clk);
                    #1 busy_b = 1'b0;
                end
            end
        end
    end

    // Monitor: pops expectations whenever an instance presents an output
    task automatic mon(input int d, input logic st, input logic [7:0] b, input logic bz,
                       input logic [NR-1:0] u, input logic dn, input logic er);
        logic [7:0] eb;
        evt_t       ev;
        bit         have;
        if (st === 1'b1) begin
            chk($sformatf("dut%0d tx_busy at tx_start", d), 32'(bz), 32'd0);
            have = 0;
            if (d == 0 && qtx0.size() > 0) begin eb = qtx0.pop_front(); have = 1; end
            if (d == 1 && qtx1.size() > 0) begin eb = qtx1.pop_front(); have = 1; end
            if (have) chk($sformatf("dut%0d tx_byte", d), 32'(b), 32'(eb));
            else begin
                n_chk++; n_fail++;
                $display("FAIL dut%0d unexpected tx_start: got byte %h, required none", d, b);
            end
        end
        if (dn === 1'b1) begin
            have = 0;
            if (d == 0 && qev0.size() > 0) begin ev = qev0.pop_front(); have = 1; end
            if (d == 1 && qev1.size() > 0) begin ev = qev1.pop_front(); have = 1; end
            if (have) begin
                chk($sformatf("dut%0d upd", d), 32'(u), 32'(ev.upd));
                chk($sformatf("dut%0d frame_err", d), 32'(er), 32'(ev.err));
            end else begin
                n_chk++; n_fail++;
                $display("FAIL dut%0d unexpected frame_done: got 1, required 0", d);
            end
        end else begin
            if (u !== '0) begin
                n_chk++; n_fail++;
                $display("FAIL dut%0d upd without frame: got %h, required 0", d, u);
            end
            if (er === 1'b1) begin
                n_chk++;
                if (d == 0 && to0 > 0) to0--;
                else if (d == 1 && to1 > 0) to1--;
                else begin
                    n_fail++;
                    $display("FAIL dut%0d unexpected frame_err: got 1, required 0", d);
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            mon(0, start_a, txb_a, busy_a, upd_a, done_a, err_a);
            mon(1, start_b, txb_b, busy_b, upd_b, done_b, err_b);
        end
    end

    // Drive one byte starting at a negedge, then an optional random gap
    task automatic send_byte(input logic [7:0] b, input bit gap);
        rx_valid = 1'b1;
        rx_byte  = b;
        @(negedge clk);
        rx_valid = 1'b0;
        if (gap) repeat ($urandom_range(0, 3)) @(negedge clk);
    endtask

    task automatic push_tx(input int d, input logic [7:0] b);
        if (d == 0) qtx0.push_back(b); else qtx1.push_back(b);
    endtask

    task automatic push_ev(input int d, input logic [NR-1:0] u, input logic e);
        evt_t ev;
        ev.upd = u;
        ev.err = e;
        if (d == 0) qev0.push_back(ev); else qev1.push_back(ev);
    endtask

    // Full frame: model computes the expected response from the frame rules
    task automatic send_frame(input logic [31:0] data, input logic [7:0] ctrl);
        logic [7:0]  cs;
        logic [31:0] m;
        int          a;
        cs = data[7:0] + data[15:8] + data[23:16] + data[31:24];
        a  = int'(ctrl[6:0]);
        for (int d = 0; d < 2; d++) begin
            m = (d == 0) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
            if (a >= int'(NR)) begin
                push_ev(d, '0, 1'b1);
                push_tx(d, cs ^ 8'hFF);
            end else if (ctrl[7]) begin
                push_ev(d, '0, 1'b0);
                for (int k = 0; k < int'(PB); k++) push_tx(d, 8'(mreg[d][a] >> (8 * k)));
            end else begin
                mreg[d][a] = data & m;
                push_ev(d, NR'(1) << a, 1'b0);
                push_tx(d, cs);
            end
        end
        for (int k = 0; k < int'(PB); k++) send_byte(8'(data >> (8 * k)), 1'b1);
        send_byte(ctrl, 1'b0);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((qtx0.size() + qtx1.size() + qev0.size() + qev1.size()) != 0 && t < 3000) begin
            @(negedge clk); #2; t++;
        end
        chk("responses drained within budget",
            32'(qtx0.size() + qtx1.size() + qev0.size() + qev1.size()), 32'd0);
        repeat (8) @(negedge clk);
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < int'(NR); i++) begin
            chk($sformatf("%s dut0 regs[%0d]", tag, i), regs_a[i*32 +: 32], mreg[0][i]);
            chk($sformatf("%s dut1 regs[%0d]", tag, i), 32'(regs_b[i*16 +: 16]), mreg[1][i]);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, " tx_start"},   32'({start_a, start_b}), 32'd0);
        chk({tag, " tx_byte"},    32'({txb_a, txb_b}), 32'd0);
        chk({tag, " upd"},        32'({upd_a, upd_b}), 32'd0);
        chk({tag, " frame_done"}, 32'({done_a, done_b}), 32'd0);
        chk({tag, " frame_err"},  32'({err_a, err_b}), 32'd0);
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < int'(NR); i++) mreg[d][i] = rv_word(d, i);
    endtask

    initial begin
        int          t;
        logic [7:0]  c;
        int          r;
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_byte  = 8'h00;
        model_reset();
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        check_regs("reset");
        rst = 1'b0;
        @(negedge clk);

        // Write PERIOD then read it back
        send_frame(32'h000F_0000, 8'h01);
        wait_idle();
        check_regs("write PERIOD");
        send_frame($urandom, 8'h81);
        wait_idle();
        check_regs("read PERIOD");

        // Bad address
        send_frame(32'h0403_0201, 8'h7F);
        wait_idle();
        check_regs("bad address");

        // Inter-byte timeout discards the partial frame
        to0 = 1; to1 = 1;
        send_byte(8'h55, 1'b0);
        send_byte(8'hAA, 1'b0);
        repeat (TO + 30) @(negedge clk);
        chk("dut0 timeout frame_err seen", 32'(to0), 32'd0);
        chk("dut1 timeout frame_err seen", 32'(to1), 32'd0);
        to0 = 0; to1 = 0;
        send_frame(32'h0000_00C8, 8'h00);
        wait_idle();
        check_regs("after timeout");

        // Reset while a read response is still being sent
        busy_max = 30;
        send_frame($urandom, 8'h82);
        t = 0;
        while (qtx0.size() >= PB && t < 500) begin @(negedge clk); #2; t++; end
        chk("first read byte issued before reset", 32'(qtx0.size() < PB), 32'd1);
        rst = 1'b1;
        qtx0.delete(); qtx1.delete(); qev0.delete(); qev1.delete();
        to0 = 0; to1 = 0;
        model_reset();
        @(negedge clk); #2;
        rst = 1'b0;
        busy_max = 6;
        repeat (60) @(negedge clk);
        check_idle_outputs("after mid-send reset");
        check_regs("after mid-send reset");
        send_frame(32'h1234_5678, 8'h03);
        wait_idle();
        check_regs("frame after reset");

        // Checksum wrap and truncation on the 16-bit instance
        send_frame(32'h3412_FFFF, 8'h02);
        wait_idle();
        check_regs("wrap/truncate");

        // Randomised frames
        for (int n = 0; n < 40; n++) begin
            r = int'($urandom_range(0, 11));
            c = (r == 11) ? 8'h7F : 8'(r);
            if ($urandom_range(0, 1) == 1) c[7] = 1'b1;
            send_frame($urandom, c);
            wait_idle();
            check_regs($sformatf("random %0d", n));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global time limit: got timeout, required completion");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/pulse_cmd_regfile.md
Name: pulse_cmd_regfile

Overview:
Parametrised command decoder and register bank for the pulse generator's serial control path. It consumes a received-byte stream from the UART: PAYLOAD_BYTES data bytes, LSB first, followed by one control byte. It then writes or reads one of NUM_REGS pulse-parameter registers and queues a response byte stream back to the UART transmitter. It adds readback, address checking, an inter-byte timeout and per-register update strobes.

Parameters:
PAYLOAD_BYTES, 4, data bytes per frame before the control byte (1..8)
NUM_REGS, 9, number of parameter registers (1..127)
REG_W, 32, width of each register; must be ≤ 8*PAYLOAD_BYTES
RESET_VALS, 0, flattened NUM_REGS*REG_W reset image; register i sits at [i*REG_W +: REG_W]
TIMEOUT_CYC, 2000000, idle clk cycles mid-frame before the partial frame is discarded (0 = disabled)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
rx_valid  in  1  one-cycle pulse: rx_byte is valid
rx_byte  in  8  received byte
tx_busy  in  1  UART transmitter busy
tx_start  out  1  one-cycle pulse: load tx_byte into the UART
tx_byte  out  8  byte to transmit
regs  out  NUM_REGS*REG_W  all register values, flattened
upd  out  NUM_REGS  one-cycle strobe on the written register's bit
frame_done  out  1  one-cycle pulse when a frame executes
frame_err  out  1  one-cycle pulse on timeout or bad address

Behaviour:
- Reset (rst=1 at a clk edge):
  - regs=RESET_VALS; state=RECV; byte count 0; checksum 0.
  - tx_start, tx_byte, upd, frame_done and frame_err all 0.
  - Reset mid-frame or mid-send discards the frame. No further tx_start is issued.
- Control byte: bit7 = R (1=read, 0=write); bits[6:0] = register address.
- RECV state:
  - For each rx_valid, store the byte at payload[8*cnt +: 8], add it to an 8-bit checksum (mod 256) and increment cnt.
  - When cnt==PAYLOAD_BYTES, the next rx_valid byte is the control byte; go to EXEC.
  - rx_valid is ignored in every state other than RECV.
- Timeout:
  - While cnt>0 in RECV, a counter counts cycles since the last rx_valid.
  - On reaching TIMEOUT_CYC: clear cnt and checksum, pulse frame_err, stay in RECV, send nothing.
- EXEC state (exactly 1 cycle):
  - Address ≥ NUM_REGS: no register change; pulse frame_err; queue 1 response byte = checksum ^ 8'hFF.
  - Valid write: reg[addr] <= payload[REG_W-1:0]; upd[addr] pulses in this cycle, and the new value appears on regs the cycle after; queue 1 response byte = checksum.
  - Valid read: no register change; queue PAYLOAD_BYTES response bytes = zero-extended reg[addr], LSB first.
  - frame_done pulses in EXEC for every frame that reaches EXEC, including bad-address frames.
  - Go to SEND.
- SEND state, per queued byte:
  - Wait for tx_busy=0, then pulse tx_start for 1 cycle with tx_byte set.
  - Then wait for tx_busy to rise (or 2 cycles, whichever is first) before testing tx_busy=0 again, so one byte is never issued twice.
  - After the last byte, return to RECV with cnt=0 and checksum=0.
- Latency: frame_done is 1 cycle after the control-byte rx_valid. The first tx_start is ≥2 cycles after it, when tx_busy=0.
- Simultaneous events: a timeout and an rx_valid in the same cycle → the rx_valid wins and the timer reloads. rst dominates everything.
- Widths: truncation above REG_W on writes is silent. The checksum wraps mod 256.

Decomposition:
- Package pulse_cmd_pkg holds:
  - state enum (RECV, EXEC, SEND);
  - CTRL_READ_BIT=7 and the address-field width;
  - NAK_XOR=8'hFF;
  - named address constants: DELAY=0, PERIOD=1, PULSE1=2, PULSE2=3, BLOCK=4, CPMG=5, ATT=6, NUTW=7, NUTD=8.
- One sub-module, pulse_cmd_tx_seq: response byte queue plus tx_busy handshake. It holds up to 8 bytes, is loaded in EXEC, and emits tx_start pulses.

Test Plan:
- Write PERIOD: bytes 0x00,0x00,0x0F,0x00, ctrl 0x01 → regs[1]=0x000F0000, upd=9'b000000010 for 1 cycle, frame_done pulse, response byte 0x0F.
- Read back: bytes ×4 any value, ctrl 0x81 after the write above → 4 tx bytes 0x00,0x00,0x0F,0x00 in order, one tx_start each, each issued only after tx_busy falls.
- Bad address: bytes 0x01,0x02,0x03,0x04, ctrl 0x7F → no regs change, upd=0, frame_err pulse, response 0xF5 (0x0A^0xFF).
- Timeout: 2 bytes, then idle TIMEOUT_CYC cycles (bench value 100) → frame_err pulse, nothing sent. Then a full DELAY write 0xC8,0,0,0 ctrl 0x00 → regs[0]=200, response 0xC8.
- Reset mid-SEND: rst asserted while a read response is pending → no further tx_start, regs=RESET_VALS, and the next frame decodes correctly.
- Checksum wrap plus truncation with REG_W=16: bytes 0xFF,0xFF,0x12,0x34, ctrl 0x02 → regs[2]=0xFFFF, response 0x44.
